pt_check: RTL

- Streaming plaintext validator directly downstream of the ARC4 decrypt datapath inside the cracking engine.
- Consumes decrypted bytes for one candidate key, one byte per handshake, and decides whether every byte is printable ASCII.
- Reports pass/fail plus the first failing index, and raises an early-abort so the engine can stop the PRGA and advance to the next 24-bit key.
- Message length is the length byte (ct_mem address 0), supplied by the engine at start.

---
 rtl/arc4_pkg.sv | 21 ++
 rtl/pt_check_if.sv | 32 +++
 rtl/pt_check.sv | 118 +++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 cracking engine.
//   pt_state_t   : states of the plaintext checker FSM
//   CHAR_LO_DEF  : lowest printable ASCII byte accepted (inclusive)
//   CHAR_HI_DEF  : highest printable ASCII byte accepted (inclusive)
//   MSG_LEN_W    : width of message length / byte counters
//   KEY_W        : width of the candidate key searched by the engine
package arc4_pkg;

  localparam int MSG_LEN_W = 8;
  localparam int KEY_W     = 24;

  localparam logic [7:0] CHAR_LO_DEF = 8'h20;
  localparam logic [7:0] CHAR_HI_DEF = 8'h7E;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } pt_state_t;

endpackage

// File: rtl/pt_check_if.sv
// Handshake and result bundle between the crack engine and pt_check.
//   start/msg_len/rdy          : message start request, accepted when rdy=1
//   in_valid/in_data/in_ready  : plaintext byte stream, one byte per handshake
//   done/pass/abort/bad_idx    : verdict; done and abort are one-cycle pulses
//   byte_cnt                   : bytes accepted so far in the current message
// Modports: master = engine side, slave = checker side.
interface pt_check_if;
  import arc4_pkg::*;

  logic                 start;
  logic [MSG_LEN_W-1:0] msg_len;
  logic                 rdy;
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 done;
  logic                 pass;
  logic                 abort;
  logic [MSG_LEN_W-1:0] bad_idx;
  logic [MSG_LEN_W-1:0] byte_cnt;

  modport master (
    output start, msg_len, in_valid, in_data,
    input  rdy, in_ready, done, pass, abort, bad_idx, byte_cnt
  );

  modport slave (
    input  start, msg_len, in_valid, in_data,
    output rdy, in_ready, done, pass, abort, bad_idx, byte_cnt
  );

endinterface

// File: rtl/pt_check.sv
// Streaming plaintext validator following the ARC4 decrypt datapath.
// Checks that every byte of one candidate message lies in [CHAR_LO, CHAR_HI],
// reporting pass/fail, the first failing index and an early-abort pulse so
// the engine can drop the current key and move on.
// Ports:
//   clk  : system clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (engine drives rst = ~rst_n)
//   bus  : pt_check_if.slave -- start/msg_len/rdy, byte stream, verdict
module pt_check
  import arc4_pkg::*;
#(
  parameter logic [7:0] CHAR_LO = CHAR_LO_DEF,
  parameter logic [7:0] CHAR_HI = CHAR_HI_DEF
) (
  input  logic        clk,
  input  logic        rst,
  pt_check_if.slave   bus
);

  pt_state_t            state_q, state_d;
  logic [MSG_LEN_W-1:0] len_q, len_d;
  logic [MSG_LEN_W-1:0] cnt_q, cnt_d;
  logic [MSG_LEN_W-1:0] bad_idx_q, bad_idx_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;   // abort request carried into FIN

  logic [MSG_LEN_W-1:0] cnt_inc;
  logic                 byte_ok;

  // msg_len tops out at 255, so cnt_q+1 never needs a ninth bit.
  assign cnt_inc = cnt_q + 8'd1;
  // Unsigned compare: 8'h80..8'hFF fall above CHAR_HI and are rejected.
  assign byte_ok = (bus.in_data >= CHAR_LO) && (bus.in_data <= CHAR_HI);

  // Outputs decode directly from registered state; no combinational path
  // from the byte stream to the verdict.
  assign bus.rdy      = (state_q == IDLE);
  assign bus.in_ready = (state_q == RUN);
  assign bus.done     = (state_q == FIN);
  assign bus.abort    = (state_q == FIN) && fail_q;
  assign bus.pass     = pass_q;
  assign bus.bad_idx  = bad_idx_q;
  assign bus.byte_cnt = cnt_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    bad_idx_d = bad_idx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d     = bus.msg_len;
          cnt_d     = '0;
          bad_idx_d = '0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          if (bus.msg_len == '0) begin
            pass_d  = 1'b1;
            state_d = FIN;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        // start is deliberately not looked at here.
        if (bus.in_valid) begin
          cnt_d = cnt_inc;              // a bad byte is still counted
          if (!byte_ok) begin
            bad_idx_d = cnt_q;
            pass_d    = 1'b0;
            fail_d    = 1'b1;
            state_d   = FIN;
          end else if (cnt_inc == len_q) begin
            pass_d  = 1'b1;
            state_d = FIN;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      bad_idx_q <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      bad_idx_q <= bad_idx_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

endmodule
